// File: rtl/rf_pkg.sv
// Shared register-file types: address/data widths and the write record
// that travels from the write-back arbiter to the register file port.
package rf_pkg;
    localparam int RF_AW    = 4;
    localparam int RF_DW    = 16;
    localparam int RF_DEPTH = 16;

    typedef logic [RF_AW-1:0] rf_addr_t;
    typedef logic [RF_DW-1:0] rf_data_t;

    typedef struct packed {
        rf_addr_t addr;
        rf_data_t data;
    } rf_wr_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant over NREQ requesters. The search starts at ptr_q and wraps;
// the pointer moves past the winner only when the grant is accepted.
module rr_arbiter
    import rf_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req_i,
    input  logic            accept_i,
    output logic [NREQ-1:0] grant_o,
    output logic [$clog2(NREQ)-1:0] ptr_o
);
    localparam int PW = $clog2(NREQ);

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] win;
    logic          found;

    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (int'(ptr_q) + k) % NREQ;
            if (!found && req_i[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
    end

    always_comb begin
        grant_o = '0;
        if (found) grant_o[win] = 1'b1;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept_i && found) begin
            ptr_d = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

    assign ptr_o = ptr_q;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter and pending-write scoreboard for the 16x16 register file.
// Build with RF_SCOREBOARD_EN defined to get busy tracking, claim_err and hazard outputs.
module regfile_wb_arbiter
    import rf_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = RF_AW,
    parameter int DW   = RF_DW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic               rd_en,
    output logic [AW-1:0]      rdaddr,
    output logic [DW-1:0]      rd_wdata,
    input  logic               claim_valid,
    input  logic [AW-1:0]      claim_addr,
    input  logic [AW-1:0]      rs1_addr,
    input  logic [AW-1:0]      rs2_addr,
    output logic               rs1_busy,
    output logic               rs2_busy,
    output logic               claim_err
);
    logic [NREQ-1:0]         grant;
    logic [$clog2(NREQ)-1:0] ptr_dbg;
    logic                    accept;
    logic                    do_write;
    rf_wr_t                  sel;
    rf_wr_t                  wr_q;
    logic                    rd_en_q;

    // The register file never back-pressures, so any grant is an acceptance.
    assign accept = |grant;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    (req_valid),
        .accept_i (accept),
        .grant_o  (grant),
        .ptr_o    (ptr_dbg)
    );

    assign req_ready = grant;

    always_comb begin
        sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel.addr = req_addr[i*AW +: AW];
                sel.data = req_data[i*DW +: DW];
            end
        end
    end

    // Register 0 reads as zero, so its writes are accepted and discarded.
    assign do_write = accept && (sel.addr != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_en_q <= 1'b0;
            wr_q    <= '0;
        end else begin
            rd_en_q <= do_write;
            if (do_write) wr_q <= sel;
        end
    end

    assign rd_en    = rd_en_q;
    assign rdaddr   = wr_q.addr;
    assign rd_wdata = wr_q.data;

`ifdef RF_SCOREBOARD_EN
    logic [RF_DEPTH-1:0] busy_q, busy_d;
    logic                claim_err_q, claim_err_d;
    logic                claim_set;
    logic                unused_dbg;

    assign claim_set  = claim_valid && (claim_addr != '0);
    assign unused_dbg = ^ptr_dbg;

    always_comb begin
        busy_d      = busy_q;
        claim_err_d = claim_err_q;
        if (rd_en_q) busy_d[rdaddr] = 1'b0;
        // Set after clear: a claim behind a completing write keeps the bit.
        if (claim_set) begin
            busy_d[claim_addr] = 1'b1;
            if (busy_q[claim_addr] && !(rd_en_q && rdaddr == claim_addr)) claim_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q      <= '0;
            claim_err_q <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            claim_err_q <= claim_err_d;
        end
    end

    assign rs1_busy  = (rs1_addr != '0) && busy_q[rs1_addr];
    assign rs2_busy  = (rs2_addr != '0) && busy_q[rs2_addr];
    assign claim_err = claim_err_q;
`else
    logic unused_sb;
    assign unused_sb = ^{claim_valid, claim_addr, rs1_addr, rs2_addr, ptr_dbg};
    assign rs1_busy  = 1'b0;
    assign rs2_busy  = 1'b0;
    assign claim_err = 1'b0;
`endif
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and scoreboard for the 16-entry × 16-bit register file. It shares the register file's single write port between `NREQ` write-back requesters using round-robin arbitration and a valid/ready handshake. It drives the port's `rd_en`/`rdaddr`/`rd_wdata` from registers. It also keeps one pending-write bit per register, so issue logic can stall on read-after-write hazards for the two read ports.

## Interface
Parameters:
- `NREQ`, 2, number of write-back requesters (2..4)
- `AW`, 4, register address width
- `DW`, 16, register data width

Ports:
- `clk` in 1: single clock; all state updates on the rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `req_valid` in NREQ: requester i holds a write
- `req_ready` out NREQ: requester i accepted this cycle
- `req_addr` in NREQ*AW: packed destination addresses, requester i at bits [i*AW +: AW]
- `req_data` in NREQ*DW: packed write data, requester i at bits [i*DW +: DW]
- `rd_en` out 1: register file write enable
- `rdaddr` out AW: register file write address
- `rd_wdata` out DW: register file write data
- `claim_valid` in 1: issue stage marks `claim_addr` as pending
- `claim_addr` in AW: destination register being claimed
- `rs1_addr`, `rs2_addr` in AW: read addresses to check
- `rs1_busy`, `rs2_busy` out 1: the addressed register has a pending write
- `claim_err` out 1: sticky flag; set when a claim targets an already-busy register

## Operation
- **Arbitration:** round-robin pointer `ptr` (0..NREQ-1).
  - The winner is the first i with `req_valid[i]`, searching from `ptr` upward with wrap-around.
  - `req_ready` is one-hot for the winner and combinational from `req_valid` and `ptr`. It is all-zero when no request is valid.
  - A requester must hold valid, address and data stable until it sees ready.
- **Pointer update:** on acceptance, `ptr` becomes winner+1 mod NREQ. With no acceptance, `ptr` holds.
- **Write issue:** the accepted write is registered into `rdaddr`/`rd_wdata`, and `rd_en` is set for that one cycle.
  - A write to address 0 is accepted (ready asserted) but dropped: `rd_en` stays 0 and `rdaddr`/`rd_wdata` hold.
  - The register file's read ports return 0 for register 0, so dropping the write loses nothing.
- **Scoreboard:** `busy[15:0]`.
  - `claim_valid` with nonzero `claim_addr` sets `busy[claim_addr]`. A claim of address 0 is ignored.
  - A cycle with `rd_en`=1 clears `busy[rdaddr]` at the same edge the register file stores the data.
  - Set and clear of the same address in the same cycle: set wins. This is a new claim issued behind a completing write.
  - A claim of a register that is busy and not being cleared that cycle sets `claim_err`. `claim_err` stays set until reset.
- **Hazard outputs:** `rsN_busy` = `busy[rsN_addr]`, combinational. It is always 0 for address 0.

## Timing
- **Reset values:** `rd_en`=0, `rdaddr`=0, `rd_wdata`=0, `ptr`=0, `busy`=0, `claim_err`=0.
- **Reset mid-operation:** reset asserted asynchronously while `rd_en`=1 forces `rd_en` low immediately. That write is lost and all busy bits clear.
- **Accept-to-write latency:** 1 cycle. A write accepted at edge k drives `rd_en` during cycle k+1 and lands in the register file at edge k+2.
- **Busy clear and readback:** the busy bit clears at that same edge k+2. From cycle k+2 on, a read of the register returns the new data and `rsN_busy` reads 0.
- **Throughput:** one write per cycle sustained. With all NREQ requesters continuously valid, each is served once every NREQ cycles.
- **Claim latency:** a claim at edge k makes `rsN_busy`=1 from cycle k+1.

## Configuration
- **`RF_SCOREBOARD_EN` defined:** the busy array, `claim_err` and the hazard outputs are built as described.
- **`RF_SCOREBOARD_EN` undefined:** no busy state is built. `rs1_busy`, `rs2_busy` and `claim_err` are tied to 0 and the claim inputs are ignored. Arbitration and write issue are unchanged.

## Structure
- **Shared package `rf_pkg`:**
  - constants `RF_AW`=4, `RF_DW`=16, `RF_DEPTH`=16
  - typedefs `rf_addr_t` and `rf_data_t`
  - struct `rf_wr_t` {addr, data}
- **Sub-module `rr_arbiter`:** the NREQ-wide round-robin grant with its pointer. Inputs are the request vector and an accept strobe; output is a one-hot grant.
- **Top level:** holds the write registers and the scoreboard.

## Test plan
- **Single write:** req0 writes addr 3 data 0xBEEF → `req_ready[0]`=1; next cycle `rd_en`=1, `rdaddr`=3, `rd_wdata`=0xBEEF.
- **Round-robin fairness:** req0 and req1 both held valid for 4 cycles after reset → grants 0,1,0,1; `rd_en` high for 4 consecutive cycles.
- **Address-0 drop:** req1 writes addr 0 data 0x1234 → `req_ready[1]`=1, `rd_en` stays 0, `rdaddr`/`rd_wdata` unchanged.
- **Scoreboard set and clear:**
  - claim addr 5 → `rs1_busy`=1 with `rs1_addr`=5.
  - write to addr 5 accepted at edge k → `rs1_busy`=0 from cycle k+2.
- **Simultaneous events:**
  - claim addr 7 in the same cycle `rd_en`=1 with `rdaddr`=7 → busy[7] stays 1 and `claim_err`=0.
  - a second claim of addr 7 → `claim_err`=1.
- **Reset mid-operation:** assert `rst_n`=0 while `rd_en`=1 with busy[2]=1 → `rd_en`=0 immediately, all busy bits 0, `ptr`=0.
